// File: rtl/updown_counter_thold.sv
// ---------------------------------------------------------------------------
// updown_counter_thold
// Synchronous modulo-MODULUS up/down counter built from toggle cells with
// hold, parallel load and an illegal-load flag. All state updates happen on
// the falling edge of i_clk; i_clear is an asynchronous active-high reset.
//
// Build option:
//   UPDOWN_SATURATE_EN  defined   -> counting saturates at 0 / MODULUS-1
//                       undefined -> counting wraps modulo MODULUS (default)
//
// Cascading: o_tc of a stage drives i_nhold of the next, more significant
// stage, so the upper stage advances exactly on the lower stage's wrap.
// ---------------------------------------------------------------------------
module updown_counter_thold #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             i_clk,
  input  logic             i_clear,
  input  logic             i_nhold,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_up,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_nq,
  output logic             o_tc,
  output logic             o_err
);

  // Largest legal count value, and the modulus widened by one bit so that
  // MODULUS == 2**WIDTH still compares correctly against a WIDTH-bit load.
  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] r_q;
  logic             r_err;

  logic             w_at_max;
  logic             w_at_zero;
  logic             w_d_legal;
  logic [WIDTH-1:0] w_inc_mask;
  logic [WIDTH-1:0] w_dec_mask;
  logic [WIDTH-1:0] w_up_mask;
  logic [WIDTH-1:0] w_dn_mask;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_toggle;

  assign w_at_max  = (r_q == MAX_Q);
  assign w_at_zero = (r_q == '0);
  assign w_d_legal = ({1'b0, i_d} < MOD_EXT);

  // Toggle masks for an ordinary binary step: the bits that differ between
  // Q and Q+1 (or Q-1). Only used away from the range limits.
  assign w_inc_mask = r_q ^ (r_q + WIDTH'(1));
  assign w_dec_mask = r_q ^ (r_q - WIDTH'(1));

  // Limit handling is an explicit mask rather than binary overflow so that a
  // modulus below 2**WIDTH wraps at MODULUS-1 instead of at all-ones.
  // Wrap up: toggling every set bit of MAX_Q lands on 0.
  // Wrap down: toggling the bits of MAX_Q from 0 lands on MAX_Q.
  always_comb begin
    w_up_mask = w_inc_mask;
    w_dn_mask = w_dec_mask;
`ifdef UPDOWN_SATURATE_EN
    if (w_at_max)  w_up_mask = '0;
    if (w_at_zero) w_dn_mask = '0;
`else
    if (w_at_max)  w_up_mask = r_q;
    if (w_at_zero) w_dn_mask = MAX_Q;
`endif
  end

  // An out-of-range load is trapped to 0 so Q never leaves 0..MODULUS-1.
  assign w_load_val = w_d_legal ? i_d : '0;

  // Per-bit toggle terms with priority load > hold > count.
  always_comb begin
    w_toggle = '0;
    if (i_load) begin
      w_toggle = r_q ^ w_load_val;
    end else if (i_nhold) begin
      w_toggle = i_up ? w_up_mask : w_dn_mask;
    end
  end

  // Toggle cells: each bit flips on the falling edge when its term is set.
  always_ff @(negedge i_clk or posedge i_clear) begin
    if (i_clear) begin
      r_q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (w_toggle[i]) r_q[i] <= ~r_q[i];
      end
    end
  end

  // Illegal-load flag: only a load touches it; holds through counting.
  always_ff @(negedge i_clk or posedge i_clear) begin
    if (i_clear) begin
      r_err <= 1'b0;
    end else if (i_load) begin
      r_err <= ~w_d_legal;
    end
  end

  assign o_q   = r_q;
  assign o_nq  = ~r_q;
  assign o_err = r_err;
  assign o_tc  = i_nhold & ~i_load & (i_up ? w_at_max : w_at_zero);

endmodule

// File: tb/tb_updown_counter_thold.sv
// ---------------------------------------------------------------------------
// tb_updown_counter_thold
// Directed cases with literal expectations, a randomized run checked against
// a modulo-arithmetic model every falling edge, and a two-stage decimal
// cascade. Honours UPDOWN_SATURATE_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_updown_counter_thold;

  localparam int W   = 4;
  localparam int MOD = 10;

  logic         clk = 1'b1;
  logic         clear;
  logic         nhold;
  logic         load;
  logic [W-1:0] d;
  logic         up;
  logic [W-1:0] q, nq;
  logic         tc, err;

  logic         cas_en;
  logic [W-1:0] lo_q, lo_nq, hi_q, hi_nq;
  logic         lo_tc, lo_err, hi_tc, hi_err;

  int n_pass  = 0;
  int n_total = 0;
  int m_q     = 0;
  int m_err   = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  updown_counter_thold #(.WIDTH(W), .MODULUS(MOD)) dut (
    .i_clk(clk), .i_clear(clear), .i_nhold(nhold), .i_load(load),
    .i_d(d), .i_up(up), .o_q(q), .o_nq(nq), .o_tc(tc), .o_err(err)
  );

  updown_counter_thold #(.WIDTH(W), .MODULUS(MOD)) u_lo (
    .i_clk(clk), .i_clear(clear), .i_nhold(cas_en), .i_load(1'b0),
    .i_d('0), .i_up(1'b1), .o_q(lo_q), .o_nq(lo_nq), .o_tc(lo_tc), .o_err(lo_err)
  );

  updown_counter_thold #(.WIDTH(W), .MODULUS(MOD)) u_hi (
    .i_clk(clk), .i_clear(clear), .i_nhold(lo_tc), .i_load(1'b0),
    .i_d('0), .i_up(1'b1), .o_q(hi_q), .o_nq(hi_nq), .o_tc(hi_tc), .o_err(hi_err)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: what Q/ERR must become after one falling edge.
  function automatic void model_step();
    if (load) begin
      if (int'(d) < MOD) begin m_q = int'(d); m_err = 0; end
      else               begin m_q = 0;       m_err = 1; end
    end else if (nhold) begin
`ifdef UPDOWN_SATURATE_EN
      if (up) m_q = (m_q == MOD - 1) ? m_q : m_q + 1;
      else    m_q = (m_q == 0)       ? 0   : m_q - 1;
`else
      if (up) m_q = (m_q + 1) % MOD;
      else    m_q = (m_q + MOD - 1) % MOD;
`endif
    end
  endfunction

  // Single compare process: update the model on each falling edge, then
  // check all outputs once they have settled.
  always @(negedge clk) begin
    if (clear) begin
      m_q = 0; m_err = 0;
    end else begin
      model_step();
    end
    #2;
    if (chk_en) begin
      chk("q",   int'(q),   m_q);
      chk("nq",  int'(nq),  (~m_q) & ((1 << W) - 1));
      chk("err", int'(err), m_err);
      chk("tc",  int'(tc),
          int'(nhold && !load && (up ? (m_q == MOD - 1) : (m_q == 0))));
    end
  end

  // Advance one falling edge; inputs are driven only after this returns.
  task automatic edge_();
    @(negedge clk);
    #4;
  endtask

  task automatic drive(input bit l, input int dv, input bit nh, input bit u);
    load = l; d = W'(dv); nhold = nh; up = u;
  endtask

`ifdef UPDOWN_SATURATE_EN
  int exp_up[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 9, 9};
  int exp_dn[3]  = '{0, 0, 0};
`else
  int exp_up[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int exp_dn[3]  = '{0, 9, 8};
`endif

  initial begin
    clear = 1'b1; cas_en = 1'b0;
    drive(0, 0, 1, 1);
    #2;
    chk("reset_q",   int'(q),   0);
    chk("reset_nq",  int'(nq),  15);
    chk("reset_err", int'(err), 0);
    edge_();
    chk("reset_hold_q", int'(q), 0);
    clear = 1'b0;
    chk_en = 1'b1;

    // Count from 0 upward: literal sequence and TC only at 9.
    for (int i = 0; i < 12; i++) begin
      edge_();
      chk("up_seq_q", int'(q), exp_up[i]);
      chk("up_seq_tc", int'(tc), int'(exp_up[i] == 9));
    end

    // Down from 1.
    drive(1, 1, 1, 1);
    edge_();
    drive(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      edge_();
      chk("dn_seq_q", int'(q), exp_dn[i]);
      chk("dn_seq_tc", int'(tc), int'(exp_dn[i] == 0));
    end

    // Hold at 4, then load overrides hold.
    drive(1, 4, 1, 1);
    edge_();
    drive(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      edge_();
      chk("hold_q", int'(q), 4);
      chk("hold_tc", int'(tc), 0);
    end
    drive(1, 6, 0, 1);
    edge_();
    chk("load_over_hold_q", int'(q), 6);

    // Illegal load, ERR sticky through counting, cleared by legal load.
    drive(1, 12, 1, 1);
    edge_();
    chk("bad_load_q", int'(q), 0);
    chk("bad_load_err", int'(err), 1);
    drive(0, 0, 1, 1);
    edge_();
    chk("err_sticky", int'(err), 1);
    drive(1, 3, 1, 1);
    edge_();
    chk("good_load_q", int'(q), 3);
    chk("good_load_err", int'(err), 0);

    // Asynchronous clear mid-count at Q=7, between falling edges.
    drive(1, 7, 1, 1);
    edge_();
    drive(1, 12, 1, 1);
    edge_();
    drive(1, 7, 1, 1);
    edge_();
    chk("pre_clear_err", int'(err), 0);
    drive(0, 0, 1, 1);
    #3;
    clear = 1'b1;
    #1;
    chk("async_clear_q",  int'(q),  0);
    chk("async_clear_nq", int'(nq), 15);
    chk("async_clear_err", int'(err), 0);
    edge_();
    chk("clear_held_q", int'(q), 0);
    edge_();
    chk("clear_held_q2", int'(q), 0);
    clear = 1'b0;

    // Randomized run against the model.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(7) == 0), int'($urandom_range(15)),
            ($urandom_range(3) != 0), $urandom_range(1));
      edge_();
    end

`ifndef UPDOWN_SATURATE_EN
    // Decimal cascade 00 -> 99 -> 00.
    chk_en = 1'b0;
    drive(0, 0, 0, 1);
    clear = 1'b1;
    #1;
    clear = 1'b0;
    cas_en = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      edge_();
      chk("cas_lo", int'(lo_q), n % 10);
      chk("cas_hi", int'(hi_q), (n / 10) % 10);
    end
    cas_en = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
